ansi_port_frame_serializer: RTL

// - Upstream feeder stage for ANSI-port semantic testcases.
// - Accepts one frame on a valid/ready handshake: an unpacked array of FOO lanes, each

---
 rtl/ansi_port_frame_serializer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ansi_port_frame_serializer.sv
// ansi_port_frame_serializer
//   Accepts one frame of FOO lanes (each FOO bits wide) on a valid/ready
//   handshake and replays it one lane per beat on a narrow valid/ready output.
//   Completed frames are counted on a 32-bit signed port.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     frame offered
//   in_ready     frame can be accepted (registered)
//   in_data      unpacked frame, lane 0 is sent first
//   out_valid    lane beat valid (registered)
//   out_ready    downstream accepts beat
//   out_data     current lane (registered)
//   out_index    index of current lane
//   out_last     current beat is lane FOO-1 (registered)
//   frame_count  frames fully delivered, wraps as 32-bit two's complement
module ansi_port_frame_serializer #(
    parameter  int FOO   = 4,
    localparam int IDX_W = $clog2(FOO)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FOO-1:0]   in_data [FOO],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FOO-1:0]   out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output int               frame_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FOO - 1);

    state_t           state_r;
    state_t           state_next_s;
    logic [FOO-1:0]   buf_r [FOO];
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_next_s;
    logic [IDX_W-1:0] idx_inc_s;
    logic [FOO-1:0]   data_next_s;
    int               count_next_s;
    logic             load_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_last_r;
    logic [FOO-1:0]   out_data_r;
    int               frame_count_r;

    assign idx_inc_s = idx_r + IDX_W'(1);

    // Next-state, next lane index, next output lane and frame counter.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        data_next_s  = out_data_r;
        count_next_s = frame_count_r;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    // Lane 0 goes straight to the output register so it is
                    // presented in the cycle right after capture.
                    state_next_s = SEND;
                    idx_next_s   = '0;
                    data_next_s  = in_data[0];
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (out_valid_r && out_ready) begin
                    if (idx_r == LAST_IDX) begin
                        count_next_s = frame_count_r + 32'sd1;
                        state_next_s = IDLE;
                    end else begin
                        idx_next_s  = idx_inc_s;
                        data_next_s = buf_r[idx_inc_s];
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, index and registered outputs. Handshake outputs are derived from
    // the next state so in_ready only rises in the cycle after the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            idx_r         <= '0;
            in_ready_r    <= 1'b0;
            out_valid_r   <= 1'b0;
            out_last_r    <= 1'b0;
            out_data_r    <= '0;
            frame_count_r <= 32'sd0;
        end else begin
            state_r       <= state_next_s;
            idx_r         <= idx_next_s;
            in_ready_r    <= (state_next_s == IDLE);
            out_valid_r   <= (state_next_s == SEND);
            out_last_r    <= (state_next_s == SEND) && (idx_next_s == LAST_IDX);
            out_data_r    <= data_next_s;
            frame_count_r <= count_next_s;
        end
    end

    // Frame buffer: written only at capture, isolating the frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FOO; i++) begin
                buf_r[i] <= '0;
            end
        end else if (load_s) begin
            buf_r <= in_data;
        end else begin
            buf_r <= buf_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_index   = idx_r;
    assign out_last    = out_last_r;
    assign frame_count = frame_count_r;

endmodule
